// File: rtl/decoder_scan_nx2n.sv
// decoder_scan_nx2n: registered N-to-2^N one-hot decoder with a direct
// hold mode and a timed scan mode that walks a one-hot bit over a range.
//
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   mode        : 0 = direct, 1 = scan (sampled on accept)
//   in_valid    : request valid
//   in_ready    : request can be accepted (low while scanning)
//   d_in        : direct index, or scan start index
//   scan_last   : scan end index (sampled on accept)
//   scan_abort  : terminate an active scan without scan_done
//   out_clr     : clear a held direct output
//   d_out       : decoded one-hot output (registered)
//   out_valid   : d_out currently asserts bit sel_out
//   sel_out     : index currently driven on d_out
//   busy        : scan in progress
//   scan_done   : one-cycle pulse on normal scan completion
module decoder_scan_nx2n #(
   parameter int SEL_W      = 4,
   parameter int DWELL      = 1,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_W-1:0]      d_in,
   input  logic [SEL_W-1:0]      scan_last,
   input  logic                  scan_abort,
   input  logic                  out_clr,
   output logic [(1<<SEL_W)-1:0] d_out,
   output logic                  out_valid,
   output logic [SEL_W-1:0]      sel_out,
   output logic                  busy,
   output logic                  scan_done
);

   localparam int OUT_W = 1 << SEL_W;

   localparam logic             POL      = (ACTIVE_LOW != 0);
   localparam logic [OUT_W-1:0] IDLE_PAT = {OUT_W{POL}};
   localparam logic [7:0]       DW_LAST  = 8'(DWELL - 1);

   if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
      $error("decoder_scan_nx2n: DWELL must be in 1..255");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } state_t;

   state_t            state_q;
   logic [SEL_W-1:0]  sel_q;
   logic [SEL_W-1:0]  end_q;
   logic [7:0]        cnt_q;
   logic [OUT_W-1:0]  dout_q;
   logic              valid_q;
   logic              busy_q;
   logic              done_q;
   logic              ready_q;

   logic              accept_d;
   logic              step_d;
   logic              last_d;
   logic [SEL_W-1:0]  sel_inc_d;

   // Bit idx asserted in the configured polarity, all other bits idle.
   function automatic logic [OUT_W-1:0] pattern(
      input logic [SEL_W-1:0] idx
   );
      logic [OUT_W-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return POL ? ~oh : oh;
   endfunction

   // ready_q mirrors (state_q != SCAN) so the handshake is registered.
   assign accept_d  = in_valid && ready_q;
   assign step_d    = (cnt_q == DW_LAST);
   assign last_d    = (sel_q == end_q);
   assign sel_inc_d = SEL_W'(sel_q + 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         end_q   <= '0;
         cnt_q   <= '0;
         dout_q  <= IDLE_PAT;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE, HOLD: begin
               if (accept_d) begin
                  sel_q   <= d_in;
                  dout_q  <= pattern(d_in);
                  valid_q <= 1'b1;
                  cnt_q   <= '0;
                  if (mode) begin
                     end_q   <= scan_last;
                     busy_q  <= 1'b1;
                     ready_q <= 1'b0;
                     state_q <= SCAN;
                  end else begin
                     state_q <= HOLD;
                  end
               end else if (state_q == HOLD && out_clr) begin
                  dout_q  <= IDLE_PAT;
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            SCAN: begin
               // Abort takes priority over a coincident final step.
               if (scan_abort) begin
                  dout_q  <= IDLE_PAT;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (step_d) begin
                  cnt_q <= '0;
                  if (last_d) begin
                     dout_q  <= IDLE_PAT;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     ready_q <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     sel_q  <= sel_inc_d;
                     dout_q <= pattern(sel_inc_d);
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: begin
               dout_q  <= IDLE_PAT;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign d_out     = dout_q;
   assign out_valid = valid_q;
   assign sel_out   = sel_q;
   assign busy      = busy_q;
   assign scan_done = done_q;
   assign in_ready  = ready_q;

endmodule

// File: tb/tb_decoder_scan_nx2n.sv
// tb_decoder_scan_nx2n: three decoder configurations driven in parallel,
// checked by a schedule-based reference model plus directed sequences.
module tb_decoder_scan_nx2n;

   logic             clk;
   logic             rst_n;
   logic             mode;
   logic             in_valid;
   logic [3:0]       d_in;
   logic [3:0]       scan_last;
   logic             scan_abort;
   logic             out_clr;

   logic [2:0][15:0] dout;
   logic [2:0][3:0]  sel;
   logic [2:0]       rdy;
   logic [2:0]       ov;
   logic [2:0]       bsy;
   logic [2:0]       dn;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // unit 0: DWELL=2 active-high, 1: DWELL=3 active-high, 2: DWELL=1 active-low
   for (genvar g = 0; g < 3; g++) begin : g_dut
      decoder_scan_nx2n #(
         .SEL_W     (4),
         .DWELL     (g == 0 ? 2 : (g == 1 ? 3 : 1)),
         .ACTIVE_LOW(g == 2 ? 1 : 0)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .mode      (mode),
         .in_valid  (in_valid),
         .in_ready  (rdy[g]),
         .d_in      (d_in),
         .scan_last (scan_last),
         .scan_abort(scan_abort),
         .out_clr   (out_clr),
         .d_out     (dout[g]),
         .out_valid (ov[g]),
         .sel_out   (sel[g]),
         .busy      (bsy[g]),
         .scan_done (dn[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dw(input int u);
      return (u == 0) ? 2 : ((u == 1) ? 3 : 1);
   endfunction

   function automatic bit al(input int u);
      return (u == 2);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Reference model: a scan is a precomputed schedule of indices, one
   // entry per output cycle; direct mode is a held index.
   int q[3][$];
   bit hv[3];
   int hi[3];
   bit md[3];

   always @(posedge clk or negedge rst_n) begin
      for (int u = 0; u < 3; u++) begin
         if (!rst_n) begin
            q[u].delete();
            hv[u] = 0;
            hi[u] = 0;
            md[u] = 0;
         end else begin
            md[u] = 0;
            if (q[u].size() > 0) begin
               if (scan_abort) begin
                  q[u].delete();
               end else begin
                  void'(q[u].pop_front());
                  if (q[u].size() == 0) md[u] = 1;
               end
            end else if (in_valid) begin
               if (!mode) begin
                  hv[u] = 1;
                  hi[u] = int'(d_in);
               end else begin
                  int n;
                  hv[u] = 0;
                  n = ((int'(scan_last) - int'(d_in) + 16) % 16) + 1;
                  for (int k = 0; k < n; k++)
                     for (int d = 0; d < dw(u); d++)
                        q[u].push_back((int'(d_in) + k) % 16);
               end
            end else if (out_clr) begin
               hv[u] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int u = 0; u < 3; u++) begin
            bit          v;
            bit          scn;
            int          s;
            logic [15:0] e;
            scn = (q[u].size() > 0);
            v   = scn || hv[u];
            s   = scn ? q[u][0] : hi[u];
            e   = v ? 16'(1 << s) : 16'h0;
            if (al(u)) e = ~e;
            chk($sformatf("m%0d.d_out", u), 32'(dout[u]), 32'(e));
            chk($sformatf("m%0d.out_valid", u), 32'(ov[u]), 32'(v));
            chk($sformatf("m%0d.busy", u), 32'(bsy[u]), 32'(scn));
            chk($sformatf("m%0d.in_ready", u), 32'(rdy[u]), 32'(!scn));
            chk($sformatf("m%0d.scan_done", u), 32'(dn[u]), 32'(md[u]));
            if (v) chk($sformatf("m%0d.sel_out", u), 32'(sel[u]), 32'(s));
         end
      end
   end

   typedef struct {
      logic        vld;
      logic [3:0]  din;
      logic        clr;
      logic [15:0] exp_hi;
      logic [15:0] exp_lo;
   } vec_t;

   vec_t vec[21];
   int   wexp[8];

   initial begin
      for (int i = 0; i < 16; i++)
         vec[i] = '{1'b1, 4'(i), 1'b0, 16'(1 << i), ~16'(1 << i)};
      vec[16] = '{1'b1, 4'd3, 1'b1, 16'h0008, 16'hFFF7};
      vec[17] = '{1'b0, 4'd0, 1'b1, 16'h0000, 16'hFFFF};
      vec[18] = '{1'b0, 4'd0, 1'b1, 16'h0000, 16'hFFFF};
      vec[19] = '{1'b1, 4'hA, 1'b0, 16'h0400, 16'hFBFF};
      vec[20] = '{1'b0, 4'd0, 1'b1, 16'h0000, 16'hFFFF};
      wexp = '{14, 14, 15, 15, 0, 0, 1, 1};

      rst_n = 0; mode = 0; in_valid = 0; d_in = 0;
      scan_last = 0; scan_abort = 0; out_clr = 0;
      #12;
      for (int u = 0; u < 3; u++) begin
         chk("rst.d_out", 32'(dout[u]), al(u) ? 32'hFFFF : 32'h0);
         chk("rst.sel_out", 32'(sel[u]), 32'h0);
         chk("rst.out_valid", 32'(ov[u]), 32'h0);
         chk("rst.busy", 32'(bsy[u]), 32'h0);
         chk("rst.scan_done", 32'(dn[u]), 32'h0);
         chk("rst.in_ready", 32'(rdy[u]), 32'h1);
      end
      cyc();
      rst_n  = 1;
      chk_en = 1;

      // direct decode table, back-to-back accepts
      for (int i = 0; i < 21; i++) begin
         mode = 0; in_valid = vec[i].vld;
         d_in = vec[i].din; out_clr = vec[i].clr;
         cyc();
         chk($sformatf("tbl%0d.hi", i), 32'(dout[0]), 32'(vec[i].exp_hi));
         chk($sformatf("tbl%0d.hi3", i), 32'(dout[1]), 32'(vec[i].exp_hi));
         chk($sformatf("tbl%0d.lo", i), 32'(dout[2]), 32'(vec[i].exp_lo));
      end
      in_valid = 0; out_clr = 0;
      cyc();

      // wrapping scan 14..1, DWELL=2 on unit 0
      mode = 1; d_in = 4'd14; scan_last = 4'd1; in_valid = 1;
      cyc();
      in_valid = 0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("wrap%0d.sel", k), 32'(sel[0]), 32'(wexp[k]));
         chk($sformatf("wrap%0d.dout", k), 32'(dout[0]), 32'(1 << wexp[k]));
         chk($sformatf("wrap%0d.rdy", k), 32'(rdy[0]), 32'h0);
         chk($sformatf("wrap%0d.done", k), 32'(dn[0]), 32'h0);
         cyc();
      end
      chk("wrap.done", 32'(dn[0]), 32'h1);
      chk("wrap.idle", 32'(dout[0]), 32'h0);
      chk("wrap.rdy", 32'(rdy[0]), 32'h1);
      cyc();
      chk("wrap.done_once", 32'(dn[0]), 32'h0);
      repeat (5) cyc();

      // single-index scan 5..5, DWELL=3 on unit 1
      mode = 1; d_in = 4'd5; scan_last = 4'd5; in_valid = 1;
      cyc();
      in_valid = 0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("one%0d.dout", k), 32'(dout[1]), 32'h0020);
         chk($sformatf("one%0d.done", k), 32'(dn[1]), 32'h0);
         cyc();
      end
      chk("one.done", 32'(dn[1]), 32'h1);
      chk("one.idle", 32'(dout[1]), 32'h0);
      repeat (3) cyc();

      // abort at index 7 on unit 2 (DWELL=1)
      mode = 1; d_in = 4'd0; scan_last = 4'd15; in_valid = 1;
      cyc();
      in_valid = 0;
      repeat (7) cyc();
      chk("abort.sel7", 32'(sel[2]), 32'd7);
      scan_abort = 1;
      cyc();
      scan_abort = 0;
      chk("abort.busy", 32'(bsy[2]), 32'h0);
      chk("abort.idle", 32'(dout[2]), 32'hFFFF);
      chk("abort.nodone", 32'(dn[2]), 32'h0);
      chk("abort.rdy", 32'(rdy[2]), 32'h1);
      mode = 0; d_in = 4'd9; in_valid = 1;
      cyc();
      in_valid = 0;
      chk("abort.next_sel", 32'(sel[2]), 32'd9);
      chk("abort.next_dout", 32'(dout[2]), 32'hFDFF);
      out_clr = 1;
      cyc();
      out_clr = 0;
      chk("abort.clr", 32'(dout[2]), 32'hFFFF);

      // asynchronous reset at index 9 on unit 2
      mode = 1; d_in = 4'd0; scan_last = 4'd15; in_valid = 1;
      cyc();
      in_valid = 0;
      repeat (9) cyc();
      chk("areset.sel9", 32'(sel[2]), 32'd9);
      #2 rst_n = 0;
      #1;
      chk("areset.busy2", 32'(bsy[2]), 32'h0);
      chk("areset.idle2", 32'(dout[2]), 32'hFFFF);
      chk("areset.busy0", 32'(bsy[0]), 32'h0);
      chk("areset.idle0", 32'(dout[0]), 32'h0);
      cyc();
      rst_n = 1;
      mode = 0; d_in = 4'd4; in_valid = 1;
      cyc();
      in_valid = 0;
      chk("areset.direct", 32'(dout[0]), 32'h0010);
      chk("areset.valid", 32'(ov[0]), 32'h1);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         in_valid   = ($urandom % 2) == 0;
         mode       = ($urandom % 10) < 3;
         d_in       = 4'($urandom);
         scan_last  = (($urandom % 4) == 0) ? 4'($urandom)
                                            : 4'(d_in + $urandom_range(0, 3));
         scan_abort = ($urandom % 40) == 0;
         out_clr    = ($urandom % 8) == 0;
         cyc();
      end
      in_valid = 0; scan_abort = 0; out_clr = 0;
      repeat (60) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
